// File: rtl/mult_pkg.sv
// Shared constants for the sequential 8x8 multiplier: FSM states and the
// per-step alignment of each 4x4 partial product.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Left shift applied to the partial product of each step
    localparam int unsigned SHIFT_S0 = 0;
    localparam int unsigned SHIFT_S1 = 4;
    localparam int unsigned SHIFT_S2 = 4;
    localparam int unsigned SHIFT_S3 = 8;

    // Zero-extend an 8-bit partial product and align it for the given step
    function automatic logic [15:0] align_partial(input logic [7:0] p, input logic [1:0] s);
        logic [15:0] ext;
        ext = {8'h00, p};
        case (s)
            2'd0:    align_partial = ext << SHIFT_S0;
            2'd1:    align_partial = ext << SHIFT_S1;
            2'd2:    align_partial = ext << SHIFT_S2;
            default: align_partial = ext << SHIFT_S3;
        endcase
    endfunction

endpackage

// File: rtl/mult4x4.sv
// Combinational 4x4 unsigned multiplier shared across the four steps.
module mult4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // Full 8-bit product of two nibbles
    always_comb begin
        p = {4'h0, a} * {4'h0, b};
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one 4x4 partial product per cycle
// over four CALC steps, accumulated into the product register.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int CLR_ON_START = 1
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [1:0]  step
);

    state_t      state;
    state_t      next_state;
    logic [1:0]  step_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  partial;
    logic        accept;

    // Step bit 1 selects the high nibble of a, bit 0 the high nibble of b
    always_comb begin
        nib_a = step_q[1] ? a_q[7:4] : a_q[3:0];
        nib_b = step_q[0] ? b_q[7:4] : b_q[3:0];
    end

    mult4x4 u_mult (
        .a (nib_a),
        .b (nib_b),
        .p (partial)
    );

    // Next-state logic and decoded outputs
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (step_q == 2'd3) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand capture, step counter and accumulator; the counter wraps
    // 3 -> 0 on the last CALC cycle so it already reads 0 in DONE
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            a_q    <= '0;
            b_q    <= '0;
            step_q <= '0;
            acc    <= '0;
        end else if (accept) begin
            a_q    <= dataa;
            b_q    <= datab;
            step_q <= '0;
            if (CLR_ON_START != 0) begin
                acc <= '0;
            end
        end else if (state == CALC) begin
            acc    <= acc + align_partial(partial, step_q);
            step_q <= step_q + 2'd1;
        end
    end

    assign product = acc;
    assign step    = step_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed and randomized operations
// checked against plain-arithmetic expectations.
module tb_mult_seq_ctrl;

    logic        clk;
    logic        aclr;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [1:0]  step;
    logic        busy2;
    logic        done2;
    logic [15:0] product2;
    logic [1:0]  step2;

    int total;
    int bad;

    mult_seq_ctrl dut (
        .clk     (clk),
        .aclr    (aclr),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .busy    (busy),
        .done    (done),
        .product (product),
        .step    (step)
    );

    mult_seq_ctrl #(.CLR_ON_START(0)) dut_acc (
        .clk     (clk),
        .aclr    (aclr),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .busy    (busy2),
        .done    (done2),
        .product (product2),
        .step    (step2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full operation on the default instance. Called just after a
    // negedge; start is accepted at the following posedge. With noise,
    // start and operands are scrambled while the sequence runs.
    task automatic test_op(input logic [7:0] a, input logic [7:0] b, input bit noise);
        logic [15:0] exp;
        exp   = 16'(a) * 16'(b);
        start = 1'b1;
        dataa = a;
        datab = b;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                total++;
                if (busy !== 1'b1 || done !== 1'b0 || step !== 2'(k - 1)) begin
                    bad++;
                    $display("FAIL op_calc k=%0d busy=%b done=%b step=%0d want busy=1 done=0 step=%0d",
                             k, busy, done, step, k - 1);
                end
                if (k == 1) begin
                    total++;
                    if (product !== 16'h0000) begin
                        bad++;
                        $display("FAIL op_clear product=%h want 0000", product);
                    end
                end
            end else begin
                total++;
                if (done !== 1'b1 || busy !== 1'b0 || step !== 2'd0 || product !== exp) begin
                    bad++;
                    $display("FAIL op_done a=%h b=%h done=%b busy=%b step=%0d product=%h want done=1 busy=0 step=0 product=%h",
                             a, b, done, busy, step, product, exp);
                end
            end
            if (noise && k < 4) begin
                start = 1'($urandom_range(0, 1));
                dataa = 8'($urandom());
                datab = 8'($urandom());
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || step !== 2'd0 || product !== exp) begin
            bad++;
            $display("FAIL op_hold done=%b busy=%b step=%0d product=%h want done=0 busy=0 step=0 product=%h",
                     done, busy, step, product, exp);
        end
    endtask

    task automatic test_reset();
        aclr  = 1'b1;
        start = 1'b0;
        dataa = 8'h00;
        datab = 8'h00;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 || step !== 2'd0) begin
            bad++;
            $display("FAIL reset busy=%b done=%b product=%h step=%0d want all zero", busy, done, product, step);
        end
        aclr = 1'b0;
        // first start right after release is accepted on the next edge
        test_op(8'h12, 8'h34, 1'b0);
    endtask

    task automatic test_directed();
        test_op(8'hFF, 8'hFF, 1'b0);
        test_op(8'h00, 8'hA5, 1'b0);
        test_op(8'h12, 8'h34, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa [2];
        logic [7:0] ob [2];
        oa[0] = 8'h0F; ob[0] = 8'h10;
        oa[1] = 8'h10; ob[1] = 8'h10;
        start = 1'b1;
        dataa = oa[0];
        datab = ob[0];
        for (int i = 0; i < 2; i++) begin
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k <= 4) begin
                    total++;
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        bad++;
                        $display("FAIL b2b_calc op=%0d k=%0d busy=%b done=%b want busy=1 done=0", i, k, busy, done);
                    end
                end else begin
                    total++;
                    if (done !== 1'b1 || product !== 16'(oa[i]) * 16'(ob[i])) begin
                        bad++;
                        $display("FAIL b2b_done op=%0d done=%b product=%h want done=1 product=%h",
                                 i, done, product, 16'(oa[i]) * 16'(ob[i]));
                    end
                    if (i == 0) begin
                        dataa = oa[1];
                        datab = ob[1];
                    end else begin
                        start = 1'b0;
                    end
                end
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_abort();
        start = 1'b1;
        dataa = 8'h12;
        datab = 8'h34;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (step !== 2'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre step=%0d busy=%b want step=2 busy=1", step, busy);
        end
        #2 aclr = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 || step !== 2'd0) begin
            bad++;
            $display("FAIL abort_async busy=%b done=%b product=%h step=%0d want all zero", busy, done, product, step);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) aclr = 1'b0;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_nodone k=%0d done=%b busy=%b want 0 0", k, done, busy);
            end
        end
        test_op(8'h03, 8'h05, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            test_op(8'($urandom()), 8'($urandom()), 1'b1);
        end
    endtask

    // Accumulating instance: running sum of products modulo 2^16
    task automatic test_clr0();
        logic [15:0] acc_model;
        logic [7:0]  a;
        logic [7:0]  b;
        aclr = 1'b1;
        @(negedge clk);
        aclr      = 1'b0;
        acc_model = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin a = 8'h02; b = 8'h03; end
            else if (i == 1) begin a = 8'h01; b = 8'h01; end
            else begin a = 8'($urandom()); b = 8'($urandom()); end
            start = 1'b1;
            dataa = a;
            datab = b;
            @(negedge clk);
            start = 1'b0;
            total++;
            if (busy2 !== 1'b1 || product2 !== acc_model) begin
                bad++;
                $display("FAIL clr0_keep op=%0d busy=%b product=%h want busy=1 product=%h", i, busy2, product2, acc_model);
            end
            acc_model = acc_model + 16'(a) * 16'(b);
            repeat (4) @(negedge clk);
            total++;
            if (done2 !== 1'b1 || product2 !== acc_model) begin
                bad++;
                $display("FAIL clr0_done op=%0d done=%b product=%h want done=1 product=%h", i, done2, product2, acc_model);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        aclr  = 1'b1;
        start = 1'b0;
        dataa = 8'h00;
        datab = 8'h00;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random();
        test_clr0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
